// File: rtl/i2c_slave_core.sv
// Byte-level I2C target: oversampled SCL/SDA, START/STOP detect, 7-bit address
// match, ACK generation, received-byte delivery and host-supplied read data.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       CLOCK_i,
    input  logic       RESET_i,
    input  logic       SCL_i,
    input  logic       SDA_i,
    output logic       SDA_OE_o,
    input  logic [7:0] TX_DATA_i,
    output logic       TX_LOAD_o,
    output logic [7:0] RX_DATA_o,
    output logic       RX_VALID_o,
    output logic       DIR_o,
    output logic       BUSY_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;
    logic       scl;
    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_d;
    logic [7:0] rx_shift;
    logic [7:0] rx_shift_d;
    logic [7:0] tx_shift;
    logic [7:0] tx_shift_d;
    logic [7:0] rx_data;
    logic [7:0] rx_data_d;
    logic       sda_oe;
    logic       sda_oe_d;
    logic       rx_valid;
    logic       rx_valid_d;
    logic       dir;
    logic       dir_d;
    logic       busy;
    logic       busy_d;
    logic       tx_load;
    logic       addr_match;

    // Synchronizers idle high so reset release never looks like a bus condition
    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL_i};
            sda_sync <= {sda_sync[0], SDA_i};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    assign scl        = scl_sync[1];
    assign sda        = sda_sync[1];
    assign scl_rise   = scl & ~scl_hist;
    assign scl_fall   = ~scl & scl_hist;
    assign start_det  = scl & scl_hist & sda_hist & ~sda;
    assign stop_det   = scl & scl_hist & ~sda_hist & sda;
    assign addr_match = (rx_shift[7:1] == SLAVE_ADDR);

    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rx_data  <= '0;
            sda_oe   <= 1'b0;
            rx_valid <= 1'b0;
            dir      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_d;
            rx_shift <= rx_shift_d;
            tx_shift <= tx_shift_d;
            rx_data  <= rx_data_d;
            sda_oe   <= sda_oe_d;
            rx_valid <= rx_valid_d;
            dir      <= dir_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_next = addr_match ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_next = dir ? TX_BYTE : RX_BYTE;
                    end
                end
                RX_BYTE: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_next = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_next = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_next = TX_ACK;
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda) begin
                        state_next = WAIT_STOP;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_next = TX_BYTE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // In TX_BYTE bit_cnt counts bits already put on the bus; in TX_ACK a 1 marks a master ACK
    always_comb begin
        bit_cnt_d  = bit_cnt;
        rx_shift_d = rx_shift;
        tx_shift_d = tx_shift;
        rx_data_d  = rx_data;
        sda_oe_d   = sda_oe;
        rx_valid_d = 1'b0;
        dir_d      = dir;
        busy_d     = busy;
        tx_load    = 1'b0;
        if (start_det) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state)
                ADDR, RX_BYTE: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        rx_shift_d = {rx_shift[6:0], sda};
                        bit_cnt_d  = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state == ADDR) begin
                            if (addr_match) begin
                                sda_oe_d = 1'b1;
                                dir_d    = rx_shift[0];
                            end
                        end else begin
                            rx_data_d  = rx_shift;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        tx_load   = dir;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            tx_shift_d = {tx_shift[6:0], 1'b0};
                            sda_oe_d   = ~tx_shift[6];
                            bit_cnt_d  = bit_cnt + 4'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !sda) begin
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        tx_load = 1'b1;
                    end
                end
                default: ;
            endcase
            if (tx_load) begin
                tx_shift_d = TX_DATA_i;
                sda_oe_d   = ~TX_DATA_i[7];
                bit_cnt_d  = 4'd1;
            end
        end
    end

    assign SDA_OE_o   = sda_oe;
    assign TX_LOAD_o  = tx_load;
    assign RX_DATA_o  = rx_data;
    assign RX_VALID_o = rx_valid;
    assign DIR_o      = dir;
    assign BUSY_o     = busy;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-banged bus master on a wired-AND SDA
// line, with monitors logging RX_VALID_o, TX_LOAD_o and SDA_OE_o activity.
module tb_i2c_slave_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       dir;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         rx_count = 0;
    int         load_count = 0;
    int         oe_count = 0;
    logic [7:0] rx_log [0:15];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_core #(.SLAVE_ADDR(7'h50)) dut (
        .CLOCK_i   (clk),
        .RESET_i   (rst),
        .SCL_i     (scl),
        .SDA_i     (sda_bus),
        .SDA_OE_o  (sda_oe),
        .TX_DATA_i (tx_data),
        .TX_LOAD_o (tx_load),
        .RX_DATA_o (rx_data),
        .RX_VALID_o(rx_valid),
        .DIR_o     (dir),
        .BUSY_o    (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_count % 16] = rx_data;
            rx_count++;
        end
        if (tx_load) load_count++;
        if (sda_oe) oe_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (5) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        wait_q();
        scl = 1'b1;
        wait_q();
        s = sda_bus;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    // next_tx is presented before the ACK bit so it is stable for the following load
    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        clock_bit(~master_ack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         rx_base;
        int         load_base;
        int         oe_base;

        rst     = 1'b1;
        scl     = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_sda_oe",   sda_oe,   1'b0);
        check("reset_tx_load",  tx_load,  1'b0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data",  rx_data,  8'h00);
        check("reset_dir",      dir,      1'b0);
        check("reset_busy",     busy,     1'b0);

        // Write A0, 3C, C3
        rx_base   = rx_count;
        load_base = load_count;
        i2c_start();
        check("wr_busy_start", busy, 1'b1);
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1'b1);
        write_byte(8'h3C, ack);
        check("wr_d0_ack", ack, 1'b1);
        write_byte(8'hC3, ack);
        check("wr_d1_ack", ack, 1'b1);
        i2c_stop();
        check("wr_rx_count", rx_count - rx_base, 2);
        check("wr_rx0", rx_log[rx_base % 16], 8'h3C);
        check("wr_rx1", rx_log[(rx_base + 1) % 16], 8'hC3);
        check("wr_dir", dir, 1'b0);
        check("wr_busy_stop", busy, 1'b0);
        check("wr_no_load", load_count - load_base, 0);
        check("wr_oe_released", sda_oe, 1'b0);

        // Address mismatch
        rx_base   = rx_count;
        load_base = load_count;
        oe_base   = oe_count;
        i2c_start();
        check("mm_busy_start", busy, 1'b1);
        write_byte(8'hA4, ack);
        check("mm_addr_nack", ack, 1'b0);
        write_byte(8'h55, ack);
        check("mm_data_nack", ack, 1'b0);
        check("mm_busy_mid", busy, 1'b1);
        i2c_stop();
        check("mm_busy_stop", busy, 1'b0);
        check("mm_no_oe", oe_count - oe_base, 0);
        check("mm_no_rx", rx_count - rx_base, 0);
        check("mm_no_load", load_count - load_base, 0);

        // Read 96 (ACK), 5A (NACK)
        load_base = load_count;
        tx_data   = 8'h96;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1'b1);
        check("rd_dir", dir, 1'b1);
        read_byte(1'b1, 8'h5A, d);
        check("rd_byte0", d, 8'h96);
        read_byte(1'b0, 8'h00, d);
        check("rd_byte1", d, 8'h5A);
        check("rd_released_after_nack", sda_oe, 1'b0);
        wait_q();
        check("rd_still_released", sda_bus, 1'b1);
        i2c_stop();
        check("rd_load_count", load_count - load_base, 2);
        check("rd_busy_stop", busy, 1'b0);

        // Write 11, repeated START, read E7
        rx_base   = rx_count;
        load_base = load_count;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_wr_addr_ack", ack, 1'b1);
        check("rs_dir_write", dir, 1'b0);
        write_byte(8'h11, ack);
        check("rs_wr_data_ack", ack, 1'b1);
        tx_data = 8'hE7;
        i2c_start();
        check("rs_rx_count", rx_count - rx_base, 1);
        check("rs_rx_data", rx_log[rx_base % 16], 8'h11);
        check("rs_busy", busy, 1'b1);
        write_byte(8'hA1, ack);
        check("rs_rd_addr_ack", ack, 1'b1);
        check("rs_dir_read", dir, 1'b1);
        read_byte(1'b0, 8'h00, d);
        check("rs_rd_byte", d, 8'hE7);
        i2c_stop();
        check("rs_load_count", load_count - load_base, 1);

        // STOP after 4 data bits, then a normal write
        rx_base = rx_count;
        i2c_start();
        write_byte(8'hA0, ack);
        check("ps_addr_ack", ack, 1'b1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        i2c_stop();
        check("ps_no_rx", rx_count - rx_base, 0);
        check("ps_oe_released", sda_oe, 1'b0);
        check("ps_busy", busy, 1'b0);
        i2c_start();
        write_byte(8'hA0, ack);
        check("ps_next_addr_ack", ack, 1'b1);
        write_byte(8'h7E, ack);
        check("ps_next_data_ack", ack, 1'b1);
        i2c_stop();
        check("ps_next_rx_count", rx_count - rx_base, 1);
        check("ps_next_rx_data", rx_log[rx_base % 16], 8'h7E);

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hA1;
            clock_bit(d[i], s);
        end
        sda_m = 1'b1;
        check("rst_oe_before", sda_oe, 1'b1);
        check("rst_dir_before", dir, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_oe_async", sda_oe, 1'b0);
        check("rst_dir", dir, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_load", tx_load, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_q();
        i2c_start();
        write_byte(8'hA0, ack);
        check("rst_next_addr_ack", ack, 1'b1);
        i2c_stop();
        check("rst_next_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
